// File: rtl/ram_port_arbiter.sv
// Shares one registered-read block RAM between CPU fetch and data ports.
// Data wins by default; fetch is forced through after STARVE_LIMIT data wins.
module ram_port_arbiter #(
  parameter int RAM_AW       = 21,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              ram_en,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_wstrb,
  input  logic [31:0]       ram_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] r_starve;
  logic          r_i_rv;
  logic          r_d_rv;
  logic          w_starved;
  logic          w_i_gnt;
  logic          w_d_gnt;
  logic          w_unused;

  always_comb begin
    w_starved = (r_starve == LIM);
    w_i_gnt   = rst & i_req & (~d_req | w_starved);
    w_d_gnt   = rst & d_req & ~(i_req & w_starved);
  end

  assign i_gnt     = w_i_gnt;
  assign d_gnt     = w_d_gnt;
  assign ram_en    = w_i_gnt | w_d_gnt;
  assign ram_addr  = w_d_gnt ? d_addr[RAM_AW+1:2]
                             : i_addr[RAM_AW+1:2];
  assign ram_wdata = d_wdata;
  assign ram_wstrb = w_d_gnt ? d_wstrb : 4'h0;

  // byte offset and alias bits above the RAM window are ignored
  assign w_unused = ^{i_addr[31:RAM_AW+2], i_addr[1:0],
                      d_addr[31:RAM_AW+2], d_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_i_rv   <= 1'b0;
      r_d_rv   <= 1'b0;
      r_starve <= '0;
    end else begin
      r_i_rv <= w_i_gnt;
      r_d_rv <= w_d_gnt;
      if (w_i_gnt | ~i_req)
        r_starve <= '0;
      else if (w_d_gnt & ~w_starved)
        r_starve <= r_starve + 1'b1;
    end
  end

  // a response in flight is dropped if reset arrives
  assign i_rvalid = r_i_rv & rst;
  assign d_rvalid = r_d_rv & rst;
  assign i_rdata  = i_rvalid ? ram_rdata : 32'h0;
  assign d_rdata  = d_rvalid ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM plus reference model,
// directed scenarios followed by randomized traffic with resets.
module tb_ram_port_arbiter;

  localparam int AW  = 21;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0;
  logic [31:0]   i_addr = '0;
  logic          i_gnt, i_rvalid;
  logic [31:0]   i_rdata;
  logic          d_req = 1'b0;
  logic [31:0]   d_addr = '0;
  logic [31:0]   d_wdata = '0;
  logic [3:0]    d_wstrb = '0;
  logic          d_gnt, d_rvalid;
  logic [31:0]   d_rdata;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [3:0]    ram_wstrb;
  logic [31:0]   ram_rdata = '0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.RAM_AW(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb),
    .ram_rdata(ram_rdata)
  );

  // behavioural block RAM (registered read)
  logic [31:0] bram [int];
  logic [31:0] b_old;
  always @(posedge clk) begin
    if (ram_en) begin
      b_old = bram.exists(int'(ram_addr)) ? bram[int'(ram_addr)] : 32'h0;
      for (int b = 0; b < 4; b++)
        if (ram_wstrb[b]) begin
          if (!bram.exists(int'(ram_addr))) bram[int'(ram_addr)] = 32'h0;
          bram[int'(ram_addr)][8*b +: 8] = ram_wdata[8*b +: 8];
        end
      ram_rdata <= b_old;
    end
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model state
  logic [31:0] ref_mem [int];
  int          m_starve = 0;
  bit          m_i_rv = 0, m_d_rv = 0, m_d_wr = 0;
  logic [31:0] m_i_data = '0, m_d_data = '0;
  bit          e_i_gnt = 0, e_d_gnt = 0;

  function automatic int widx(logic [31:0] a);
    return int'((a >> 2) % (32'd1 << AW));
  endfunction

  function automatic logic [31:0] rd(int w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  task automatic preload(int w, logic [31:0] v);
    ref_mem[w] = v;
    bram[w]    = v;
  endtask

  // compare DUT against the model in the current cycle
  task automatic eval();
    bit xi, xd;
    @(negedge clk);
    e_i_gnt = 0;
    e_d_gnt = 0;
    if (rst_n) begin
      if (d_req && i_req) begin
        if (m_starve == LIM) e_i_gnt = 1;
        else e_d_gnt = 1;
      end else if (d_req) e_d_gnt = 1;
      else if (i_req) e_i_gnt = 1;
    end
    chk("i_gnt", i_gnt, e_i_gnt);
    chk("d_gnt", d_gnt, e_d_gnt);
    chk("ram_en", ram_en, e_i_gnt | e_d_gnt);
    chk("ram_wstrb", ram_wstrb, e_d_gnt ? d_wstrb : 4'h0);
    if (e_d_gnt) begin
      chk("ram_addr_d", ram_addr, widx(d_addr));
      chk("ram_wdata", ram_wdata, d_wdata);
    end else if (e_i_gnt)
      chk("ram_addr_i", ram_addr, widx(i_addr));
    xi = m_i_rv && rst_n;
    xd = m_d_rv && rst_n;
    chk("i_rvalid", i_rvalid, xi);
    chk("i_rdata", i_rdata, xi ? m_i_data : 32'h0);
    chk("d_rvalid", d_rvalid, xd);
    if (!xd) chk("d_rdata_idle", d_rdata, 32'h0);
    else if (!m_d_wr) chk("d_rdata", d_rdata, m_d_data);
  endtask

  // advance the model past the coming clock edge
  task automatic adv();
    logic [31:0] v;
    int w;
    m_i_rv = e_i_gnt;
    if (e_i_gnt) m_i_data = rd(widx(i_addr));
    m_d_rv = e_d_gnt;
    if (e_d_gnt) begin
      w = widx(d_addr);
      m_d_wr = (d_wstrb != 4'h0);
      if (m_d_wr) begin
        v = rd(w);
        for (int b = 0; b < 4; b++)
          if (d_wstrb[b]) v[8*b +: 8] = d_wdata[8*b +: 8];
        ref_mem[w] = v;
      end else m_d_data = rd(w);
    end
    if (!rst_n || e_i_gnt || !i_req) m_starve = 0;
    else if (e_d_gnt && m_starve < LIM) m_starve++;
    @(posedge clk);
    #1;
  endtask

  string pat3 = "DDDDIDDDDIDD";

  initial begin
    // reset state
    eval();
    chk("rst_i_rvalid", i_rvalid, 1'b0);
    chk("rst_ram_en", ram_en, 1'b0);
    adv();
    eval();
    adv();
    rst_n = 1'b1;

    // fetch read of word 4
    preload(4, 32'hDEADBEEF);
    i_req = 1; i_addr = 32'h80000010;
    eval();
    chk("t1_gnt", i_gnt, 1'b1);
    chk("t1_addr", ram_addr, 32'd4);
    adv();
    i_req = 0;
    eval();
    chk("t1_rvalid", i_rvalid, 1'b1);
    chk("t1_rdata", i_rdata, 32'hDEADBEEF);
    adv();

    // partial write then read back
    preload(8, 32'h11223344);
    d_req = 1; d_addr = 32'h80000020;
    d_wdata = 32'hAABBCCDD; d_wstrb = 4'b0011;
    eval();
    adv();
    d_wstrb = 4'h0; d_wdata = '0;
    eval();
    chk("t2_rd_gnt", d_gnt, 1'b1);
    adv();
    d_req = 0;
    eval();
    chk("t2_rdata", d_rdata, 32'h1122CCDD);
    adv();

    // both requesting: starvation guard pattern
    d_req = 1; d_addr = 32'h00000100;
    i_req = 1; i_addr = 32'h00000200;
    for (int k = 0; k < 12; k++) begin
      eval();
      chk("t3_dgnt", d_gnt, pat3[k] == "D");
      chk("t3_ignt", i_gnt, pat3[k] == "I");
      adv();
    end
    d_req = 0; i_req = 0;
    eval();
    adv();

    // fetch stream, one access per cycle
    for (int k = 0; k < 8; k++) preload(16 + k, 32'hC0DE0000 + k);
    for (int k = 0; k < 9; k++) begin
      i_req  = (k < 8);
      i_addr = 32'h80000040 + 4 * k;
      eval();
      if (k < 8) chk("t4_gnt", i_gnt, 1'b1);
      if (k > 0) chk("t4_rdata", i_rdata, 32'hC0DE0000 + k - 1);
      adv();
    end

    // reset while a data read is in flight
    d_req = 1; i_req = 1;
    d_addr = 32'h80000020; i_addr = 32'h80000010;
    for (int k = 0; k < 3; k++) begin
      eval();
      adv();
    end
    eval();
    chk("t5_pre_gnt", d_gnt, 1'b1);
    adv();
    rst_n = 0;
    eval();
    chk("t5_rvalid", d_rvalid, 1'b0);
    chk("t5_dgnt", d_gnt, 1'b0);
    chk("t5_ignt", i_gnt, 1'b0);
    adv();
    rst_n = 1;
    for (int k = 0; k < 5; k++) begin
      eval();
      chk("t5_post", d_gnt, k < 4);
      adv();
    end
    d_req = 0; i_req = 0;
    eval();
    adv();

    // address aliasing above the RAM window
    preload(0, 32'h0BADF00D);
    d_req = 1; d_addr = 32'h80800000; d_wstrb = 4'h0;
    eval();
    chk("t6_addr", ram_addr, 32'd0);
    adv();
    d_req = 0;
    eval();
    chk("t6_rdata", d_rdata, 32'h0BADF00D);
    adv();

    // randomized traffic with occasional reset
    for (int k = 0; k < 32; k++) preload(k, $urandom());
    for (int n = 0; n < 3000; n++) begin
      if (!i_req || e_i_gnt) begin
        i_req  = ($urandom_range(0, 9) < 6);
        i_addr = ($urandom() & 32'hFF80_0000)
               | (32'($urandom_range(0, 31)) << 2)
               | 32'($urandom_range(0, 3));
      end
      if (!d_req || e_d_gnt) begin
        d_req   = ($urandom_range(0, 9) < 6);
        d_addr  = ($urandom() & 32'hFF80_0000)
                | (32'($urandom_range(0, 31)) << 2)
                | 32'($urandom_range(0, 3));
        d_wdata = $urandom();
        d_wstrb = ($urandom_range(0, 1) == 1)
                ? 4'($urandom_range(1, 15)) : 4'h0;
      end
      rst_n = ($urandom_range(0, 99) != 0);
      eval();
      adv();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
